// File: rtl/mcpu_pkg.sv
// Shared MCPU ISA definitions: opcode map, operand sizes and the decoded trace record.
// Used by both the CPU control decoder and the fetch trace decoder.
package mcpu_pkg;

  localparam int unsigned WORD_SIZE    = 16;
  localparam int unsigned OPERAND_SIZE = 4;
  localparam int unsigned PC_SIZE      = 8;

  localparam logic [OPERAND_SIZE-1:0] OP_SHORT_TO_REG  = 4'h0;
  localparam logic [OPERAND_SIZE-1:0] OP_ADD           = 4'h1;
  localparam logic [OPERAND_SIZE-1:0] OP_MOV           = 4'h2;
  localparam logic [OPERAND_SIZE-1:0] OP_LOAD_FROM_MEM = 4'h3;
  localparam logic [OPERAND_SIZE-1:0] OP_STORE_TO_MEM  = 4'h4;
  localparam logic [OPERAND_SIZE-1:0] OP_LSL           = 4'h5;
  localparam logic [OPERAND_SIZE-1:0] OP_LSR           = 4'h6;
  localparam logic [OPERAND_SIZE-1:0] OP_BNZ           = 4'h7;

  localparam logic [1:0] FMT_RRR = 2'd0;
  localparam logic [1:0] FMT_RR  = 2'd1;
  localparam logic [1:0] FMT_RI  = 2'd2;
  localparam logic [1:0] FMT_UNK = 2'd3;

  typedef struct packed {
    logic [PC_SIZE-1:0]        pc;
    logic [OPERAND_SIZE-1:0]   op;
    logic [1:0]                fmt;
    logic [OPERAND_SIZE-1:0]   rd;
    logic [OPERAND_SIZE-1:0]   ra;
    logic [OPERAND_SIZE-1:0]   rb;
    logic [2*OPERAND_SIZE-1:0] imm;
    logic                      err;
  } decoded_instr_t;

  function automatic logic [1:0] op_fmt(input logic [OPERAND_SIZE-1:0] op);
    logic [1:0] fmt;
    case (op)
      OP_ADD, OP_LSL, OP_LSR:                                 fmt = FMT_RRR;
      OP_MOV:                                                 fmt = FMT_RR;
      OP_SHORT_TO_REG, OP_LOAD_FROM_MEM, OP_STORE_TO_MEM, OP_BNZ: fmt = FMT_RI;
      default:                                                fmt = FMT_UNK;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/mcpu_trace_fifo.sv
// Synchronous FIFO with a registered head entry; a freshly pushed record into an empty
// FIFO becomes visible one cycle after it is written.
module mcpu_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rvalid,
  output logic [WIDTH-1:0]         rdata
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, head_next;
  logic [CntW-1:0]  count_q, count_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_pop, do_write;

  always_comb begin
    full      = (count_q == CntW'(DEPTH));
    empty     = (count_q == '0);
    do_pop    = pop && rvalid_q;
    // A full FIFO still accepts a push when the head leaves in the same edge.
    do_write  = push && (!full || do_pop);
    count_d   = count_q;
    if (do_write && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_write && do_pop) begin
      count_d = count_q - CntW'(1);
    end
    head_next = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    rvalid_d  = !empty && (count_d != '0);
    rdata_d   = rdata_q;
    if (rvalid_d) begin
      rdata_d = (do_write && (wr_ptr_q == head_next)) ? wdata : mem_q[head_next];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      rd_ptr_q <= head_next;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign count  = count_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/mcpu_fetch_decoder.sv
// Passive fetch-port snooper: captures each fetched word, splits it into ISA fields and
// queues the decoded record for a valid/ready consumer without ever stalling the CPU.
module mcpu_fetch_decoder #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned OPERAND_SIZE = 4,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      fetch_valid,
  input  logic [ADDR_W-1:0]         fetch_pc,
  input  logic [WORD_SIZE-1:0]      fetch_instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [OPERAND_SIZE-1:0]   out_op,
  output logic [1:0]                out_fmt,
  output logic [OPERAND_SIZE-1:0]   out_rd,
  output logic [OPERAND_SIZE-1:0]   out_ra,
  output logic [OPERAND_SIZE-1:0]   out_rb,
  output logic [2*OPERAND_SIZE-1:0] out_imm,
  output logic                      out_err,
  output logic [$clog2(DEPTH):0]    count,
  output logic [7:0]                drop_cnt,
  output logic                      overflow
);

  import mcpu_pkg::*;

  localparam int unsigned RecW = $bits(decoded_instr_t);

  logic                    cap_valid_q;
  logic [ADDR_W-1:0]       cap_pc_q;
  logic [WORD_SIZE-1:0]    cap_instr_q;
  logic [OPERAND_SIZE-1:0] dec_op;
  decoded_instr_t          dec_rec;
  decoded_instr_t          head_rec;
  logic                    fifo_full, fifo_empty, pop, drop;
  logic [7:0]              drop_cnt_q;
  logic                    overflow_q;

  // Capture stage is independent of enable once loaded, so a record in flight completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid_q <= 1'b0;
      cap_pc_q    <= '0;
      cap_instr_q <= '0;
    end else begin
      cap_valid_q <= fetch_valid && enable;
      if (fetch_valid && enable) begin
        cap_pc_q    <= fetch_pc;
        cap_instr_q <= fetch_instr;
      end
    end
  end

  always_comb begin
    dec_op      = cap_instr_q[WORD_SIZE-1 -: OPERAND_SIZE];
    dec_rec     = '0;
    dec_rec.pc  = PC_SIZE'(cap_pc_q);
    dec_rec.op  = dec_op;
    dec_rec.fmt = op_fmt(dec_op);
    dec_rec.rd  = cap_instr_q[2*OPERAND_SIZE +: OPERAND_SIZE];
    case (dec_rec.fmt)
      FMT_RRR: begin
        dec_rec.ra = cap_instr_q[OPERAND_SIZE +: OPERAND_SIZE];
        dec_rec.rb = cap_instr_q[0 +: OPERAND_SIZE];
      end
      FMT_RR:  dec_rec.ra  = cap_instr_q[OPERAND_SIZE +: OPERAND_SIZE];
      FMT_RI:  dec_rec.imm = cap_instr_q[0 +: 2*OPERAND_SIZE];
      default: ;
    endcase
    // MOV leaves the low nibble unused; anything there means a corrupt word.
    dec_rec.err = (dec_rec.fmt == FMT_UNK) ||
                  ((dec_op == OP_MOV) && (cap_instr_q[0 +: OPERAND_SIZE] != '0));
  end

  assign pop  = out_valid && out_ready && !fifo_empty;
  assign drop = cap_valid_q && fifo_full && !pop;

  mcpu_trace_fifo #(
    .WIDTH (RecW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (cap_valid_q),
    .wdata  (dec_rec),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count),
    .rvalid (out_valid),
    .rdata  (head_rec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign out_pc   = ADDR_W'(head_rec.pc);
  assign out_op   = head_rec.op;
  assign out_fmt  = head_rec.fmt;
  assign out_rd   = head_rec.rd;
  assign out_ra   = head_rec.ra;
  assign out_rb   = head_rec.rb;
  assign out_imm  = head_rec.imm;
  assign out_err  = head_rec.err;
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mcpu_fetch_decoder.sv
// Scoreboard bench for mcpu_fetch_decoder: expected records are queued at fetch time and
// checked by a monitor at every handshake; each scenario task also checks status inline.
module tb_mcpu_fetch_decoder;
  import mcpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [7:0]  fetch_pc = '0;
  logic [15:0] fetch_instr = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_pc;
  logic [3:0]  out_op;
  logic [1:0]  out_fmt;
  logic [3:0]  out_rd, out_ra, out_rb;
  logic [7:0]  out_imm;
  logic        out_err;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  decoded_instr_t exp_q[$];

  always #5 clk = ~clk;

  mcpu_fetch_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_op      (out_op),
    .out_fmt     (out_fmt),
    .out_rd      (out_rd),
    .out_ra      (out_ra),
    .out_rb      (out_rb),
    .out_imm     (out_imm),
    .out_err     (out_err),
    .count       (count),
    .drop_cnt    (drop_cnt),
    .overflow    (overflow)
  );

  function automatic decoded_instr_t make_rec(input logic [7:0] pc, input logic [3:0] op,
                                              input logic [1:0] fmt, input logic [3:0] rd,
                                              input logic [3:0] ra, input logic [3:0] rb,
                                              input logic [7:0] imm, input logic err);
    decoded_instr_t r;
    r.pc = pc; r.op = op; r.fmt = fmt; r.rd = rd;
    r.ra = ra; r.rb = rb; r.imm = imm; r.err = err;
    return r;
  endfunction

  function automatic decoded_instr_t model_decode(input logic [7:0] pc, input logic [15:0] w);
    decoded_instr_t r;
    logic [3:0] op;
    op = w[15:12];
    r = '0;
    r.pc = pc; r.op = op; r.rd = w[11:8];
    if (op == OP_ADD || op == OP_LSL || op == OP_LSR) begin
      r.fmt = FMT_RRR; r.ra = w[7:4]; r.rb = w[3:0];
    end else if (op == OP_MOV) begin
      r.fmt = FMT_RR; r.ra = w[7:4]; r.err = (w[3:0] != 4'h0);
    end else if (op == OP_SHORT_TO_REG || op == OP_LOAD_FROM_MEM ||
                 op == OP_STORE_TO_MEM || op == OP_BNZ) begin
      r.fmt = FMT_RI; r.imm = w[7:0];
    end else begin
      r.fmt = FMT_UNK; r.err = 1'b1;
    end
    return r;
  endfunction

  function automatic decoded_instr_t observed();
    decoded_instr_t r;
    r.pc = out_pc; r.op = out_op; r.fmt = out_fmt; r.rd = out_rd;
    r.ra = out_ra; r.rb = out_rb; r.imm = out_imm; r.err = out_err;
    return r;
  endfunction

  // Inputs change 1 time unit after posedge, so the negedge sees exactly what the next
  // posedge will sample.
  logic           hold_prev = 1'b0;
  decoded_instr_t held;
  always @(negedge clk) begin
    decoded_instr_t got, exp;
    got = observed();
    if (hold_prev && out_valid) begin
      n_tests++;
      if (got !== held) begin
        n_fail++;
        $display("FAIL hold_stable: got %h, required %h", got, held);
      end
    end
    if (out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got record %h, required none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL sb_record: got %h, required %h", got, exp);
        end
      end
    end
    hold_prev = out_valid && !out_ready;
    held      = got;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] pc, input logic [15:0] instr);
    fetch_valid = v;
    fetch_pc    = pc;
    fetch_instr = instr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_valid_count: got valid=%b count=%0d, required 0 0", out_valid, count);
    end
    n_tests++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop: got drop=%0d ovf=%b, required 0 0", drop_cnt, overflow);
    end
    n_tests++;
    if (observed() !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 0", observed());
    end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    drive(1'b1, 8'd0, {OP_ADD, 4'd2, 4'd0, 4'd1});
    exp_q.push_back(make_rec(8'd0, OP_ADD, FMT_RRR, 4'd2, 4'd0, 4'd1, 8'h00, 1'b0));
    tick();
    drive(1'b1, 8'd1, {OP_MOV, 4'd1, 4'd2, 4'd0});
    exp_q.push_back(make_rec(8'd1, OP_MOV, FMT_RR, 4'd1, 4'd2, 4'd0, 8'h00, 1'b0));
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_latency_early: got valid=%b, required 0", out_valid);
    end
    drive(1'b1, 8'd2, {OP_STORE_TO_MEM, 4'd2, 8'h14});
    exp_q.push_back(make_rec(8'd2, OP_STORE_TO_MEM, FMT_RI, 4'd2, 4'd0, 4'd0, 8'h14, 1'b0));
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'd0) begin
      n_fail++;
      $display("FAIL dec_latency: got valid=%b pc=%0d, required 1 0", out_valid, out_pc);
    end
    drive(1'b1, 8'd3, {OP_LSL, 4'd0, 4'd0, 4'd2});
    exp_q.push_back(make_rec(8'd3, OP_LSL, FMT_RRR, 4'd0, 4'd0, 4'd2, 8'h00, 1'b0));
    tick();
    drive(1'b0, 8'd0, 16'h0);
    for (int i = 1; i <= 3; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 8'(i)) begin
        n_fail++;
        $display("FAIL dec_stream: got valid=%b pc=%0d, required 1 %0d", out_valid, out_pc, i);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL dec_drain: got valid=%b pending=%0d, required 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    drive(1'b1, 8'h10, 16'hF345);
    exp_q.push_back(make_rec(8'h10, 4'hF, FMT_UNK, 4'd3, 4'd0, 4'd0, 8'h00, 1'b1));
    tick();
    drive(1'b1, 8'h11, {OP_MOV, 4'd1, 4'd2, 4'h5});
    exp_q.push_back(make_rec(8'h11, OP_MOV, FMT_RR, 4'd1, 4'd2, 4'd0, 8'h00, 1'b1));
    tick();
    drive(1'b0, 8'd0, 16'h0);
    tick();
    n_tests++;
    if (out_fmt !== FMT_UNK || out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_unknown: got fmt=%0d err=%b, required 3 1", out_fmt, out_err);
    end
    tick();
    n_tests++;
    if (out_fmt !== FMT_RR || out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_mov: got fmt=%0d err=%b, required 1 1", out_fmt, out_err);
    end
    tick();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL err_drain: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      logic [7:0] pc;
      pc = 8'(i);
      drive(1'b1, pc, {OP_ADD, pc[3:0], 4'h0, 4'h1});
      if (i < 8) exp_q.push_back(make_rec(pc, OP_ADD, FMT_RRR, pc[3:0], 4'h0, 4'h1, 8'h00, 1'b0));
      tick();
    end
    drive(1'b0, 8'd0, 16'h0);
    tick();
    tick();
    n_tests++;
    if (count !== 4'd8 || drop_cnt !== 8'd3 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_status: got count=%0d drop=%0d ovf=%b, required 8 3 1",
               count, drop_cnt, overflow);
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'd0) begin
      n_fail++;
      $display("FAIL ovf_head: got valid=%b pc=%0d, required 1 0", out_valid, out_pc);
    end
  endtask

  task automatic test_full_pop_push();
    drive(1'b1, 8'h40, {OP_SHORT_TO_REG, 4'd5, 8'hA5});
    exp_q.push_back(make_rec(8'h40, OP_SHORT_TO_REG, FMT_RI, 4'd5, 4'd0, 4'd0, 8'hA5, 1'b0));
    tick();
    drive(1'b0, 8'd0, 16'h0);
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (count !== 4'd8 || drop_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL full_popush: got count=%0d drop=%0d, required 8 3", count, drop_cnt);
    end
    repeat (12) tick();
    n_tests++;
    if (count !== 4'd0 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: got count=%0d valid=%b pending=%0d, required 0 0 0",
               count, out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h20 + i), {OP_LSR, 4'd1, 4'd2, 4'd3});
      tick();
    end
    drive(1'b0, 8'd0, 16'h0);
    n_tests++;
    if (count !== 4'd5) begin
      n_fail++;
      $display("FAIL rstmid_pre: got count=%0d, required 5", count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || count !== 4'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got valid=%b count=%0d drop=%0d ovf=%b, required 0 0 0 0",
               out_valid, count, drop_cnt, overflow);
    end
    tick();
    n_tests++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid_stage1: got count=%0d, required 0", count);
    end
    drive(1'b1, 8'h77, {OP_BNZ, 4'd3, 8'h7E});
    exp_q.push_back(make_rec(8'h77, OP_BNZ, FMT_RI, 4'd3, 4'd0, 4'd0, 8'h7E, 1'b0));
    tick();
    drive(1'b0, 8'd0, 16'h0);
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_early: got valid=%b, required 0", out_valid);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h77) begin
      n_fail++;
      $display("FAIL rstmid_fetch: got valid=%b pc=%h, required 1 77", out_valid, out_pc);
    end
    out_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_drain: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      logic        fv;
      logic        en;
      logic [7:0]  pc;
      logic [15:0] w;
      fv = ($urandom_range(0, 3) != 0) && (count < 4'd6);
      en = ($urandom_range(0, 7) != 0);
      pc = 8'($urandom_range(0, 255));
      w  = 16'($urandom_range(0, 65535));
      enable    = en;
      out_ready = ($urandom_range(0, 1) == 1);
      drive(fv, pc, w);
      if (fv && en) exp_q.push_back(model_decode(pc, w));
      tick();
    end
    drive(1'b0, 8'd0, 16'h0);
    enable    = 1'b1;
    out_ready = 1'b1;
    repeat (12) tick();
    n_tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got pending=%0d valid=%b, required 0 0", exp_q.size(), out_valid);
    end
    n_tests++;
    if (drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_drops: got drop=%0d, required 0", drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_errors();
    test_overflow();
    test_full_pop_push();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
